mips_regfile_mp: RTL and testbench

//  Parametrised MIPS general-purpose register file: two write ports, two read ports
//  and one debug read port.

---
 rtl/mips_regfile_mp_if.sv | 31 +++
 rtl/mips_regfile_mp.sv | 110 +++++++++++
 tb/tb_mips_regfile_mp.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_regfile_mp_if.sv
// Bundles the read, write, debug and scrub-control signals of the MIPS register file.
// The master side is decode/writeback; the slave side is the register file itself.
interface mips_regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we_a;
  logic [ADDR_W-1:0] wa_a;
  logic [DATA_W-1:0] wd_a;
  logic              we_b;
  logic [ADDR_W-1:0] wa_b;
  logic [DATA_W-1:0] wd_b;
  logic              clear_req;
  logic              busy;
  logic [ADDR_W-1:0] dbg_idx;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, clear_req, dbg_idx,
    input  rd1, rd2, busy, dbg_data
  );

  modport slave (
    input  ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, clear_req, dbg_idx,
    output rd1, rd2, busy, dbg_data
  );
endinterface

// File: rtl/mips_regfile_mp.sv
// Two-write, two-read MIPS register file with a debug read port, optional
// write-to-read bypass and a one-entry-per-cycle scrub engine.
module mips_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input logic               clk,
  input logic               reset,
  mips_regfile_mp_if.slave  bus
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_FIRST = (ADDR_W+1)'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   ptr_next;
  logic [ADDR_W:0]   ptr_inc;
  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_a;
  logic              wr_b;
  logic              fwd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= PTR_FIRST;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The extra pointer bit carries out exactly when entry NREGS-1 has just been cleared.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    ptr_inc    = ptr + PTR_FIRST;
    case (state)
      IDLE: begin
        if (bus.clear_req) begin
          state_next = CLEAR;
          ptr_next   = PTR_FIRST;
        end
      end
      CLEAR: begin
        ptr_next = ptr_inc;
        if (ptr_inc[ADDR_W]) begin
          state_next = IDLE;
          ptr_next   = PTR_FIRST;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = PTR_FIRST;
      end
    endcase
  end

  assign bus.busy = (state == CLEAR);
  assign wr_a     = (state == IDLE) && bus.we_a && (bus.wa_a != '0);
  assign wr_b     = (state == IDLE) && bus.we_b && (bus.wa_b != '0);
  assign fwd_en   = (BYPASS != 0) && (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[ptr[ADDR_W-1:0]] <= '0;
    end else begin
      if (wr_a && !(wr_b && (bus.wa_b == bus.wa_a))) begin
        regs[bus.wa_a] <= bus.wd_a;
      end
      if (wr_b) begin
        regs[bus.wa_b] <= bus.wd_b;
      end
    end
  end

  // Port B is the younger retire slot, so it takes precedence when forwarding.
  always_comb begin
    bus.rd1 = (bus.ra1 == '0) ? '0 : regs[bus.ra1];
    if (fwd_en && wr_b && (bus.wa_b == bus.ra1)) begin
      bus.rd1 = bus.wd_b;
    end else if (fwd_en && wr_a && (bus.wa_a == bus.ra1)) begin
      bus.rd1 = bus.wd_a;
    end
  end

  always_comb begin
    bus.rd2 = (bus.ra2 == '0) ? '0 : regs[bus.ra2];
    if (fwd_en && wr_b && (bus.wa_b == bus.ra2)) begin
      bus.rd2 = bus.wd_b;
    end else if (fwd_en && wr_a && (bus.wa_a == bus.ra2)) begin
      bus.rd2 = bus.wd_a;
    end
  end

  assign bus.dbg_data = (bus.dbg_idx == '0) ? '0 : regs[bus.dbg_idx];

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Scoreboard bench: one stimulus stream drives a bypassing and a non-bypassing
// register file, expectations come from an array-level reference model.
module tb_mips_regfile_mp;

  typedef struct {
    bit          reset;
    bit          we_a;
    int          wa_a;
    logic [31:0] wd_a;
    bit          we_b;
    int          wa_b;
    logic [31:0] wd_b;
    bit          clear_req;
    int          ra1;
    int          ra2;
    int          dbg_idx;
  } stim_t;

  typedef struct {
    int          cycle;
    logic [31:0] rd1_byp;
    logic [31:0] rd2_byp;
    logic [31:0] rd1_nob;
    logic [31:0] rd2_nob;
    logic [31:0] dbg;
    logic        busy;
  } exp_t;

  logic clk;
  logic reset;

  mips_regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_byp ();
  mips_regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_nob ();

  mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_byp)
  );

  mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nob (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the register contents plus how far a scrub has progressed.
  logic [31:0] mem [32];
  bit          scrubbing;
  int          next_clear;
  bit          model_valid;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  int   cycle_no;

  function automatic logic [31:0] model_read(input stim_t s, input int idx, input bit fwd);
    if (idx == 0) return 32'h0;
    if (fwd && !scrubbing) begin
      if (s.we_b && s.wa_b == idx) return s.wd_b;
      if (s.we_a && s.wa_a == idx) return s.wd_a;
    end
    return mem[idx];
  endfunction

  function automatic void model_step(input stim_t s);
    if (s.reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      scrubbing  = 1'b0;
      next_clear = 1;
      model_valid = 1'b1;
    end else if (scrubbing) begin
      mem[next_clear] = 32'h0;
      if (next_clear == 31) scrubbing = 1'b0;
      else next_clear = next_clear + 1;
    end else begin
      if (s.we_a && s.wa_a != 0) mem[s.wa_a] = s.wd_a;
      if (s.we_b && s.wa_b != 0) mem[s.wa_b] = s.wd_b;
      if (s.clear_req) begin
        scrubbing  = 1'b1;
        next_clear = 1;
      end
    end
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s.reset     = 1'b0;
    s.we_a      = 1'b0;
    s.wa_a      = 0;
    s.wd_a      = 32'h0;
    s.we_b      = 1'b0;
    s.wa_b      = 0;
    s.wd_b      = 32'h0;
    s.clear_req = 1'b0;
    s.ra1       = int'($urandom_range(0, 31));
    s.ra2       = int'($urandom_range(0, 31));
    s.dbg_idx   = int'($urandom_range(0, 31));
    return s;
  endfunction

  function automatic int rand_idx();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 7));
  endfunction

  task automatic drive(input stim_t s);
    reset = s.reset;
    bus_byp.we_a = s.we_a;  bus_nob.we_a = s.we_a;
    bus_byp.wa_a = 5'(s.wa_a); bus_nob.wa_a = 5'(s.wa_a);
    bus_byp.wd_a = s.wd_a;  bus_nob.wd_a = s.wd_a;
    bus_byp.we_b = s.we_b;  bus_nob.we_b = s.we_b;
    bus_byp.wa_b = 5'(s.wa_b); bus_nob.wa_b = 5'(s.wa_b);
    bus_byp.wd_b = s.wd_b;  bus_nob.wd_b = s.wd_b;
    bus_byp.clear_req = s.clear_req; bus_nob.clear_req = s.clear_req;
    bus_byp.ra1 = 5'(s.ra1); bus_nob.ra1 = 5'(s.ra1);
    bus_byp.ra2 = 5'(s.ra2); bus_nob.ra2 = 5'(s.ra2);
    bus_byp.dbg_idx = 5'(s.dbg_idx); bus_nob.dbg_idx = 5'(s.dbg_idx);
  endtask

  // Drives one cycle just after the rising edge, queues what the outputs must
  // show before the next edge, then advances the model across that edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    drive(s);
    cycle_no++;
    if (model_valid) begin
      e.cycle   = cycle_no;
      e.rd1_byp = model_read(s, s.ra1, 1'b1);
      e.rd2_byp = model_read(s, s.ra2, 1'b1);
      e.rd1_nob = model_read(s, s.ra1, 1'b0);
      e.rd2_nob = model_read(s, s.ra2, 1'b0);
      e.dbg     = (s.dbg_idx == 0) ? 32'h0 : mem[s.dbg_idx];
      e.busy    = scrubbing;
      sb.push_back(e);
    end
    model_step(s);
  endtask

  task automatic cmp(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("rd1_bypass", e.cycle, bus_byp.rd1, e.rd1_byp);
    cmp("rd2_bypass", e.cycle, bus_byp.rd2, e.rd2_byp);
    cmp("rd1_nobypass", e.cycle, bus_nob.rd1, e.rd1_nob);
    cmp("rd2_nobypass", e.cycle, bus_nob.rd2, e.rd2_nob);
    cmp("dbg_bypass", e.cycle, bus_byp.dbg_data, e.dbg);
    cmp("dbg_nobypass", e.cycle, bus_nob.dbg_data, e.dbg);
    cmp("busy_bypass", e.cycle, {31'h0, bus_byp.busy}, {31'h0, e.busy});
    cmp("busy_nobypass", e.cycle, {31'h0, bus_nob.busy}, {31'h0, e.busy});
  endtask

  // Monitor: the outputs are combinational, so every cycle presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic fill_index();
    stim_t s;
    for (int i = 1; i < 32; i++) begin
      s = quiet();
      s.we_a = 1'b1;
      s.wa_a = i;
      s.wd_a = 32'(i);
      applyStimulus(s);
    end
  endtask

  task automatic random_cycle(input bit allow_ctl);
    stim_t s;
    s = quiet();
    s.we_a = 1'($urandom_range(0, 1));
    s.wa_a = rand_idx();
    s.wd_a = $urandom;
    s.we_b = 1'($urandom_range(0, 1));
    s.wa_b = rand_idx();
    s.wd_b = $urandom;
    s.ra1  = rand_idx();
    s.ra2  = rand_idx();
    s.dbg_idx = rand_idx();
    if (allow_ctl) begin
      s.clear_req = ($urandom_range(0, 99) == 0);
      s.reset     = ($urandom_range(0, 299) == 0);
    end
    applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    int guard;
    vectors     = 0;
    miscompares = 0;
    cycle_no    = 0;
    model_valid = 1'b0;
    scrubbing   = 1'b0;
    next_clear  = 1;
    s = quiet();
    s.reset = 1'b1;
    drive(s);

    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(quiet());

    s = quiet(); s.we_a = 1'b1; s.wa_a = 5; s.wd_a = 32'hDEADBEEF;
    applyStimulus(s);
    s = quiet(); s.ra1 = 5; s.dbg_idx = 5;
    applyStimulus(s);

    s = quiet(); s.we_a = 1'b1; s.we_b = 1'b1; s.wa_a = 7; s.wa_b = 7;
    s.wd_a = 32'h1; s.wd_b = 32'h2; s.ra2 = 7; s.ra1 = 7;
    applyStimulus(s);
    s = quiet(); s.ra1 = 7; s.dbg_idx = 7;
    applyStimulus(s);

    s = quiet(); s.we_a = 1'b1; s.we_b = 1'b1; s.wa_a = 0; s.wa_b = 0;
    s.wd_a = 32'hFFFFFFFF; s.wd_b = 32'hFFFFFFFF; s.ra1 = 0; s.ra2 = 0; s.dbg_idx = 0;
    applyStimulus(s);
    s = quiet(); s.ra1 = 0; s.ra2 = 0; s.dbg_idx = 0;
    applyStimulus(s);

    s = quiet(); s.we_a = 1'b1; s.wa_a = 3; s.wd_a = 32'h55; s.ra1 = 3;
    applyStimulus(s);
    s = quiet(); s.ra1 = 3;
    applyStimulus(s);

    fill_index();
    s = quiet(); s.clear_req = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 31; i++) begin
      s = quiet();
      s.we_a = 1'b1; s.wa_a = rand_idx(); s.wd_a = $urandom;
      s.we_b = 1'b1; s.wa_b = 31;         s.wd_b = $urandom;
      s.ra1  = s.wa_a; s.ra2 = 31;
      s.clear_req = (i == 5);
      applyStimulus(s);
    end
    for (int i = 0; i < 32; i++) begin
      s = quiet(); s.ra1 = i; s.ra2 = 31 - i; s.dbg_idx = i;
      applyStimulus(s);
    end

    fill_index();
    s = quiet(); s.clear_req = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 9; i++) applyStimulus(quiet());
    s = quiet(); s.reset = 1'b1;
    applyStimulus(s);
    s = quiet(); s.ra1 = 31; s.dbg_idx = 20;
    applyStimulus(s);
    s = quiet(); s.we_a = 1'b1; s.wa_a = 31; s.wd_a = 32'hA5A5_0031; s.ra2 = 31;
    applyStimulus(s);
    s = quiet(); s.ra1 = 31; s.dbg_idx = 31;
    applyStimulus(s);

    for (int i = 0; i < 1500; i++) random_cycle(1'b1);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
